// File: rtl/plru_set_array.sv
// plru_set_array: per-set tree-PLRU state store for a set-associative cache.
//   Hit/fill touches promote a way along its tree path. Victim queries return
//   the PLRU way restricted to an evictable mask and promote the returned way.
//   Tree storage is an unreset register file that an init sweep clears after reset.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   init_busy                   high while the init sweep clears the trees
//   touch_valid/set/way         promote a way in a set
//   victim_req_valid/ready      victim query handshake (ready = !init_busy)
//   victim_req_set/evictable    queried set and evictable-way mask
//   victim_resp_valid/way       one-cycle registered response with the chosen way
//   victim_resp_fallback        mask was all-zero, so the unmasked PLRU way was returned
//   stat_touch/victim/fallback_cnt   saturating event counters
//
// Optional feature: define PLRU_STATS_EN to build the statistics counters;
// otherwise the stat_* ports are tied to zero.
//
// Tree layout: node (1<<j)+k-1 is at level j with prefix k, and node 0 is the root.
// The unmasked walk goes to child !bit at each node.

module plru_set_array #(
  parameter int WAYS = 8,
  parameter int SETS = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    init_busy,
  input  logic                    touch_valid,
  input  logic [$clog2(SETS)-1:0] touch_set,
  input  logic [$clog2(WAYS)-1:0] touch_way,
  input  logic                    victim_req_valid,
  output logic                    victim_req_ready,
  input  logic [$clog2(SETS)-1:0] victim_req_set,
  input  logic [WAYS-1:0]         victim_evictable,
  output logic                    victim_resp_valid,
  output logic [$clog2(WAYS)-1:0] victim_resp_way,
  output logic                    victim_resp_fallback,
  output logic [15:0]             stat_touch_cnt,
  output logic [15:0]             stat_victim_cnt,
  output logic [15:0]             stat_fallback_cnt
);
  localparam int LW    = $clog2(WAYS);
  localparam int LS    = $clog2(SETS);
  localparam int NODES = WAYS - 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  // Every node on the way's path takes the way's index bit for that level.
  function automatic logic [NODES-1:0] promote(input logic [NODES-1:0] t,
                                               input logic [LW-1:0] way);
    logic [NODES-1:0] r;
    logic [LW-1:0]    pre;
    logic [LW-1:0]    bsh;
    int               node;
    r = t;
    for (int j = 0; j < LW; j++) begin
      pre  = way >> (LW - j);
      bsh  = way >> (LW - 1 - j);
      node = (1 << j) + int'(pre) - 1;
      r    = (r & ~(NODES'(1) << node)) | (NODES'(bsh[0]) << node);
    end
    return r;
  endfunction

  // Masked walk: go high when the low subtree has no candidate, or when both
  // subtrees have candidates and the node points high.
  function automatic logic [LW-1:0] walk(input logic [NODES-1:0] t,
                                         input logic [WAYS-1:0]  mask,
                                         input logic             use_mask);
    logic [NODES-1:0] tsh;
    logic [WAYS-1:0]  sz_mask;
    logic [WAYS-1:0]  lo_bits;
    logic [WAYS-1:0]  hi_bits;
    logic             dir;
    int               k;
    int               size;
    k = 0;
    for (int j = 0; j < LW; j++) begin
      tsh     = t >> ((1 << j) + k - 1);
      size    = WAYS >> (j + 1);
      sz_mask = {WAYS{1'b1}} >> (WAYS - size);
      lo_bits = (mask >> (2 * k * size)) & sz_mask;
      hi_bits = (mask >> ((2 * k + 1) * size)) & sz_mask;
      if (use_mask) dir = !(|lo_bits) || ((|hi_bits) && !tsh[0]);
      else          dir = !tsh[0];
      k = 2 * k + (dir ? 1 : 0);
    end
    return LW'(k);
  endfunction

  logic [NODES-1:0] tree_q [SETS];

  state_t          state_q, state_d;
  logic [LS-1:0]   init_ptr_q, init_ptr_d;
  logic            init_busy_q, init_busy_d;
  logic            resp_valid_q, resp_valid_d;
  logic [LW-1:0]   resp_way_q, resp_way_d;
  logic            resp_fb_q, resp_fb_d;

  logic             touch_acc, victim_acc, fwd, fallback;
  logic [NODES-1:0] tree_v_eff, tree_v_new, tree_t_new;
  logic [LW-1:0]    vway;

  always_comb begin
    touch_acc  = touch_valid && (state_q == ST_RUN);
    victim_acc = victim_req_valid && !init_busy_q;
    // A same-set touch in the query cycle is applied before the walk.
    fwd        = touch_acc && victim_acc && (touch_set == victim_req_set);
    tree_v_eff = fwd ? promote(tree_q[victim_req_set], touch_way) : tree_q[victim_req_set];
    fallback   = (victim_evictable == '0);
    vway       = walk(tree_v_eff, victim_evictable, !fallback);
    tree_v_new = promote(tree_v_eff, vway);
    tree_t_new = promote(tree_q[touch_set], touch_way);

    state_d      = state_q;
    init_ptr_d   = init_ptr_q;
    if (state_q == ST_INIT) begin
      init_ptr_d = init_ptr_q + LS'(1);
      if (init_ptr_q == LS'(SETS - 1)) state_d = ST_RUN;
    end
    init_busy_d  = (state_d == ST_INIT);
    resp_valid_d = victim_acc;
    resp_way_d   = victim_acc ? vway : resp_way_q;
    resp_fb_d    = victim_acc ? fallback : resp_fb_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_INIT;
      init_ptr_q   <= '0;
      init_busy_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_way_q   <= '0;
      resp_fb_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_ptr_q   <= init_ptr_d;
      init_busy_q  <= init_busy_d;
      resp_valid_q <= resp_valid_d;
      resp_way_q   <= resp_way_d;
      resp_fb_q    <= resp_fb_d;
    end
  end

  // When the sets match, the victim write already contains the touch.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      tree_q[init_ptr_q] <= '0;
    end else begin
      if (touch_acc && !fwd) tree_q[touch_set] <= tree_t_new;
      if (victim_acc)        tree_q[victim_req_set] <= tree_v_new;
    end
  end

  assign init_busy            = init_busy_q;
  assign victim_req_ready     = !init_busy_q;
  assign victim_resp_valid    = resp_valid_q;
  assign victim_resp_way      = resp_way_q;
  assign victim_resp_fallback = resp_fb_q;

`ifdef PLRU_STATS_EN
  logic [15:0] touch_cnt_q, touch_cnt_d;
  logic [15:0] victim_cnt_q, victim_cnt_d;
  logic [15:0] fb_cnt_q, fb_cnt_d;

  always_comb begin
    touch_cnt_d  = (touch_acc && touch_cnt_q != 16'hFFFF) ? touch_cnt_q + 16'd1 : touch_cnt_q;
    victim_cnt_d = (victim_acc && victim_cnt_q != 16'hFFFF) ? victim_cnt_q + 16'd1 : victim_cnt_q;
    fb_cnt_d     = (victim_acc && fallback && fb_cnt_q != 16'hFFFF) ? fb_cnt_q + 16'd1 : fb_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      touch_cnt_q  <= '0;
      victim_cnt_q <= '0;
      fb_cnt_q     <= '0;
    end else begin
      touch_cnt_q  <= touch_cnt_d;
      victim_cnt_q <= victim_cnt_d;
      fb_cnt_q     <= fb_cnt_d;
    end
  end

  assign stat_touch_cnt    = touch_cnt_q;
  assign stat_victim_cnt   = victim_cnt_q;
  assign stat_fallback_cnt = fb_cnt_q;
`else
  assign stat_touch_cnt    = '0;
  assign stat_victim_cnt   = '0;
  assign stat_fallback_cnt = '0;
`endif

endmodule

// File: tb/tb_plru_set_array.sv
module tb_plru_set_array;
  logic        clk = 1'b0;
  logic        reset;
  logic        init_busy;
  logic        touch_valid;
  logic [5:0]  touch_set;
  logic [2:0]  touch_way;
  logic        victim_req_valid;
  logic        victim_req_ready;
  logic [5:0]  victim_req_set;
  logic [7:0]  victim_evictable;
  logic        victim_resp_valid;
  logic [2:0]  victim_resp_way;
  logic        victim_resp_fallback;
  logic [15:0] stat_touch_cnt;
  logic [15:0] stat_victim_cnt;
  logic [15:0] stat_fallback_cnt;

  always #5 clk = ~clk;

  plru_set_array #(.WAYS(8), .SETS(64)) dut (
    .clk                  (clk),
    .reset                (reset),
    .init_busy            (init_busy),
    .touch_valid          (touch_valid),
    .touch_set            (touch_set),
    .touch_way            (touch_way),
    .victim_req_valid     (victim_req_valid),
    .victim_req_ready     (victim_req_ready),
    .victim_req_set       (victim_req_set),
    .victim_evictable     (victim_evictable),
    .victim_resp_valid    (victim_resp_valid),
    .victim_resp_way      (victim_resp_way),
    .victim_resp_fallback (victim_resp_fallback),
    .stat_touch_cnt       (stat_touch_cnt),
    .stat_victim_cnt      (stat_victim_cnt),
    .stat_fallback_cnt    (stat_fallback_cnt)
  );

  typedef struct packed {
    logic [2:0] way;
    logic       fb;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   n_touch = 0;
  int   n_victim = 0;
  int   n_fb = 0;
  int   seq[8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; compare the registered response against the scoreboard head.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    touch_valid      = 1'b0;
    victim_req_valid = 1'b0;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("resp_valid", 32'(victim_resp_valid), 32'd1);
      chk("resp_way", 32'(victim_resp_way), 32'(e.way));
      chk("resp_fallback", 32'(victim_resp_fallback), 32'(e.fb));
    end else begin
      chk("resp_idle", 32'(victim_resp_valid), 32'd0);
    end
  endtask

  task automatic drv_touch(input logic [5:0] s, input logic [2:0] w);
    touch_valid = 1'b1;
    touch_set   = s;
    touch_way   = w;
    n_touch++;
  endtask

  task automatic drv_victim(input logic [5:0] s, input logic [7:0] m,
                            input logic [2:0] w, input logic fb);
    exp_t e;
    victim_req_valid = 1'b1;
    victim_req_set   = s;
    victim_evictable = m;
    e.way = w;
    e.fb  = fb;
    exp_q.push_back(e);
    n_victim++;
    if (fb) n_fb++;
  endtask

  task automatic chk_stats(input string tag);
`ifdef PLRU_STATS_EN
    chk({tag, "_touch_cnt"}, 32'(stat_touch_cnt), 32'(n_touch));
    chk({tag, "_victim_cnt"}, 32'(stat_victim_cnt), 32'(n_victim));
    chk({tag, "_fallback_cnt"}, 32'(stat_fallback_cnt), 32'(n_fb));
`else
    chk({tag, "_touch_cnt"}, 32'(stat_touch_cnt), 32'd0);
    chk({tag, "_victim_cnt"}, 32'(stat_victim_cnt), 32'd0);
    chk({tag, "_fallback_cnt"}, 32'(stat_fallback_cnt), 32'd0);
`endif
  endtask

  // Runs the init sweep with a touch on set 0 and a victim request on set 1
  // held the whole time; both must be ignored.
  task automatic wait_init(input string tag);
    int n;
    n = 0;
    chk({tag, "_busy_start"}, 32'(init_busy), 32'd1);
    chk({tag, "_ready_start"}, 32'(victim_req_ready), 32'd0);
    touch_valid      = 1'b1;
    touch_set        = 6'd0;
    touch_way        = 3'd7;
    victim_req_valid = 1'b1;
    victim_req_set   = 6'd1;
    victim_evictable = 8'hFF;
    while (init_busy === 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      chk({tag, "_resp_in_init"}, 32'(victim_resp_valid), 32'd0);
    end
    touch_valid      = 1'b0;
    victim_req_valid = 1'b0;
    chk({tag, "_init_len"}, 32'(n), 32'd64);
    chk({tag, "_ready_run"}, 32'(victim_req_ready), 32'd1);
  endtask

  initial begin
    reset            = 1'b1;
    touch_valid      = 1'b0;
    touch_set        = '0;
    touch_way        = '0;
    victim_req_valid = 1'b0;
    victim_req_set   = '0;
    victim_evictable = '0;
    seq[0] = 7; seq[1] = 3; seq[2] = 5; seq[3] = 1;
    seq[4] = 6; seq[5] = 2; seq[6] = 4; seq[7] = 0;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_init_busy", 32'(init_busy), 32'd1);
    chk("rst_ready", 32'(victim_req_ready), 32'd0);
    chk("rst_resp_valid", 32'(victim_resp_valid), 32'd0);
    chk("rst_resp_way", 32'(victim_resp_way), 32'd0);
    chk("rst_resp_fallback", 32'(victim_resp_fallback), 32'd0);
    chk_stats("rst");

    wait_init("init1");

    // fresh set, then a single-cycle response pulse
    drv_victim(6'd5, 8'hFF, 3'd7, 1'b0); step();
    step();
    // touch during init was dropped
    drv_victim(6'd0, 8'hFF, 3'd7, 1'b0); step();

    // back-to-back queries on one set, two full rounds
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++) begin
        drv_victim(6'd3, 8'hFF, 3'(seq[i]), 1'b0); step();
      end
    end

    // touch then query next cycle
    drv_touch(6'd9, 3'd7); step();
    drv_victim(6'd9, 8'hFF, 3'd3, 1'b0); step();

    // same-cycle same-set touch is forwarded
    drv_touch(6'd10, 3'd7);
    drv_victim(6'd10, 8'hFF, 3'd3, 1'b0); step();

    // same-cycle different sets update independently
    drv_touch(6'd20, 3'd7);
    drv_victim(6'd21, 8'hFF, 3'd7, 1'b0); step();
    drv_victim(6'd20, 8'hFF, 3'd3, 1'b0); step();
    drv_victim(6'd21, 8'hFF, 3'd3, 1'b0); step();

    // masked walks and the all-zero fallback
    drv_victim(6'd11, 8'h0F, 3'd3, 1'b0); step();
    drv_victim(6'd11, 8'h0F, 3'd1, 1'b0); step();
    drv_victim(6'd12, 8'h00, 3'd7, 1'b1); step();
    drv_victim(6'd12, 8'hFF, 3'd3, 1'b0); step();
    drv_victim(6'd13, 8'h10, 3'd4, 1'b0); step();
    chk_stats("run");

    // reset while a response is showing
    drv_victim(6'd30, 8'hFF, 3'd7, 1'b0); step();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    n_touch  = 0;
    n_victim = 0;
    n_fb     = 0;
    chk("mid_rst_resp_valid", 32'(victim_resp_valid), 32'd0);
    chk("mid_rst_init_busy", 32'(init_busy), 32'd1);
    chk_stats("mid_rst");

    wait_init("init2");
    drv_victim(6'd3, 8'hFF, 3'd7, 1'b0); step();
    drv_victim(6'd30, 8'hFF, 3'd7, 1'b0); step();
    chk_stats("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
